// File: rtl/uart_char_xform_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_char_xform_if
//  Description : Pin-level bundle of the UART character-transform engine.
//                The slave modport is the engine's view, the master modport
//                is the view of whatever drives rx/mode and watches the
//                transmit side.
//  Signals     : rx         serial in, idle high
//                mode       transform select (0 pass, 1 upper, 2 lower, 3 swap)
//                tx         serial out, idle high
//                tx_busy    high from start bit through end of stop bit
//                rx_ovf     one-cycle pulse, byte dropped on full FIFO
//                frame_err  one-cycle pulse, stop bit sampled low
//                fifo_level bytes currently buffered
//                rx_count / tx_count / err_count (only with
//                UART_XFORM_STATS_EN defined) wrapping event counters
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_char_xform_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int C_LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic               rx;
    logic [1:0]         mode;
    logic               tx;
    logic               tx_busy;
    logic               rx_ovf;
    logic               frame_err;
    logic [C_LVL_W-1:0] fifo_level;
`ifdef UART_XFORM_STATS_EN
    logic [15:0]        rx_count;
    logic [15:0]        tx_count;
    logic [15:0]        err_count;
`endif

    modport master (
`ifdef UART_XFORM_STATS_EN
        input  rx_count,
        input  tx_count,
        input  err_count,
`endif
        output rx,
        output mode,
        input  tx,
        input  tx_busy,
        input  rx_ovf,
        input  frame_err,
        input  fifo_level
    );

    modport slave (
`ifdef UART_XFORM_STATS_EN
        output rx_count,
        output tx_count,
        output err_count,
`endif
        input  rx,
        input  mode,
        output tx,
        output tx_busy,
        output rx_ovf,
        output frame_err,
        output fifo_level
    );
endinterface
`default_nettype wire

// File: rtl/uart_char_xform.sv
`default_nettype none
// ============================================================================
//  Module      : uart_char_xform
//  Description : 8N1 UART receiver -> byte FIFO -> case transform -> 8N1 UART
//                transmitter. RX and TX baud rates are independent; the FIFO
//                absorbs the rate mismatch.
//  Ports       : clock  master clock, rising edge
//                reset  synchronous active-high reset
//                bus    uart_char_xform_if.slave (rx, mode, tx, tx_busy,
//                       rx_ovf, frame_err, fifo_level [, stats counters])
//  Option      : UART_XFORM_STATS_EN adds rx_count / tx_count / err_count.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_char_xform #(
    parameter int CLOCK_FREQ   = 100_000_000,
    parameter int RX_BAUD_RATE = 115_200,
    parameter int TX_BAUD_RATE = 115_200,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clock,
    input  logic              reset,
    uart_char_xform_if.slave  bus
);
    localparam int C_RX_TICKS = CLOCK_FREQ / RX_BAUD_RATE;
    localparam int C_TX_TICKS = CLOCK_FREQ / TX_BAUD_RATE;
    localparam int C_RXC_W    = $clog2(C_RX_TICKS);
    localparam int C_TXC_W    = $clog2(C_TX_TICKS);
    localparam int C_AW       = $clog2(FIFO_DEPTH);
    localparam int C_LVL_W    = C_AW + 1;
    localparam logic [C_RXC_W-1:0] C_RX_LAST      = C_RXC_W'(C_RX_TICKS - 1);
    localparam logic [C_RXC_W-1:0] C_RX_HALF_LAST = C_RXC_W'(C_RX_TICKS / 2 - 1);
    localparam logic [C_TXC_W-1:0] C_TX_LAST      = C_TXC_W'(C_TX_TICKS - 1);

    typedef enum logic [2:0] {RX_ARM, RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // Letters differ from their other case only in bit 5.
    function automatic logic [7:0] xform(input logic [7:0] c, input logic [1:0] m);
        logic is_up;
        logic is_lo;
        is_up = (c >= 8'h41) && (c <= 8'h5A);
        is_lo = (c >= 8'h61) && (c <= 8'h7A);
        xform = c;
        case (m)
            2'd1:    if (is_lo) xform = c ^ 8'h20;
            2'd2:    if (is_up) xform = c ^ 8'h20;
            2'd3:    if (is_lo || is_up) xform = c ^ 8'h20;
            default: xform = c;
        endcase
    endfunction

    // ---------------- state ----------------
    logic               rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
    rx_state_t          rx_state_q, rx_state_d;
    logic [C_RXC_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]         rx_bit_q, rx_bit_d;
    logic [7:0]         rx_shift_q, rx_shift_d;
    logic [C_AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]         mem_q [FIFO_DEPTH];
    tx_state_t          tx_state_q, tx_state_d;
    logic [C_TXC_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]         tx_bit_q, tx_bit_d;
    logic [7:0]         tx_shift_q, tx_shift_d;
    logic               tx_q, tx_d, tx_busy_q, tx_busy_d;
    logic               rx_ovf_q, rx_ovf_d, frame_err_q, frame_err_d;

    logic               rx_push_w, frame_err_evt_w, ovf_evt_w, push_ok_w, pop_w, tx_done_w;
    logic               fifo_empty_w, fifo_full_w;
    logic [C_LVL_W-1:0] level_w;
    logic [7:0]         head_w;

    assign level_w      = wr_ptr_q - rd_ptr_q;
    assign fifo_empty_w = (wr_ptr_q == rd_ptr_q);
    assign fifo_full_w  = (level_w == C_LVL_W'(FIFO_DEPTH));
    assign head_w       = mem_q[rd_ptr_q[C_AW-1:0]];

    // ---------------- receiver ----------------
    always_comb begin
        rx_meta_d       = bus.rx;
        rx_sync_d       = rx_meta_q;
        rx_state_d      = rx_state_q;
        rx_cnt_d        = rx_cnt_q + C_RXC_W'(1);
        rx_bit_d        = rx_bit_q;
        rx_shift_d      = rx_shift_q;
        rx_push_w       = 1'b0;
        frame_err_evt_w = 1'b0;
        case (rx_state_q)
            // Wait for a high line so a low line at reset release is ignored.
            RX_ARM: begin
                rx_cnt_d = '0;
                if (rx_sync_q) rx_state_d = RX_IDLE;
            end
            // Only reachable with the line last seen high, so low is a 1->0 edge.
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: if (rx_cnt_q == C_RX_HALF_LAST) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == C_RX_LAST) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_cnt_q == C_RX_LAST) begin
                rx_cnt_d = '0;
                if (rx_sync_q) begin
                    rx_push_w  = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    frame_err_evt_w = 1'b1;
                    rx_state_d      = RX_ARM;
                end
            end
            default: rx_state_d = RX_ARM;
        endcase
    end

    // ---------------- FIFO ----------------
    // A pop in the same cycle frees the slot being written, even when full.
    always_comb begin
        push_ok_w   = rx_push_w && (!fifo_full_w || pop_w);
        ovf_evt_w   = rx_push_w && fifo_full_w && !pop_w;
        wr_ptr_d    = wr_ptr_q + {{C_AW{1'b0}}, push_ok_w};
        rd_ptr_d    = rd_ptr_q + {{C_AW{1'b0}}, pop_w};
        rx_ovf_d    = ovf_evt_w;
        frame_err_d = frame_err_evt_w;
    end

    always_ff @(posedge clock) begin
        if (push_ok_w) mem_q[wr_ptr_q[C_AW-1:0]] <= rx_shift_q;
    end

    // ---------------- transmitter ----------------
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + C_TXC_W'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        pop_w      = 1'b0;
        tx_done_w  = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (!fifo_empty_w) begin
                    pop_w      = 1'b1;
                    tx_shift_d = xform(head_w, bus.mode);
                    tx_state_d = TX_START;
                end
            end
            TX_START: if (tx_cnt_q == C_TX_LAST) begin
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_state_d = TX_DATA;
            end
            TX_DATA: if (tx_cnt_q == C_TX_LAST) begin
                tx_cnt_d = '0;
                if (tx_bit_q == 3'd7) begin
                    tx_state_d = TX_STOP;
                end else begin
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                end
            end
            TX_STOP: if (tx_cnt_q == C_TX_LAST) begin
                tx_cnt_d  = '0;
                tx_done_w = 1'b1;
                if (!fifo_empty_w) begin
                    pop_w      = 1'b1;
                    tx_shift_d = xform(head_w, bus.mode);
                    tx_state_d = TX_START;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        // Line and busy are registered one cycle behind the state, so the
        // start bit appears on the edge after the pop.
        case (tx_state_q)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = tx_shift_q[0];
            default:  tx_d = 1'b1;
        endcase
        tx_busy_d = (tx_state_q != TX_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q   <= 1'b0;
            rx_sync_q   <= 1'b0;
            rx_state_q  <= RX_ARM;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_q        <= 1'b1;
            tx_busy_q   <= 1'b0;
            rx_ovf_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_sync_q   <= rx_sync_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_q        <= tx_d;
            tx_busy_q   <= tx_busy_d;
            rx_ovf_q    <= rx_ovf_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.tx         = tx_q;
    assign bus.tx_busy    = tx_busy_q;
    assign bus.rx_ovf     = rx_ovf_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.fifo_level = level_w;

`ifdef UART_XFORM_STATS_EN
    logic [15:0] rx_count_q, rx_count_d, tx_count_q, tx_count_d, err_count_q, err_count_d;

    // Frame errors and overflows cannot coincide, but count one either way.
    always_comb begin
        rx_count_d  = rx_count_q + {15'd0, push_ok_w};
        tx_count_d  = tx_count_q + {15'd0, tx_done_w};
        err_count_d = err_count_q + {15'd0, frame_err_evt_w | ovf_evt_w};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_count_q  <= '0;
            tx_count_q  <= '0;
            err_count_q <= '0;
        end else begin
            rx_count_q  <= rx_count_d;
            tx_count_q  <= tx_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.rx_count  = rx_count_q;
    assign bus.tx_count  = tx_count_q;
    assign bus.err_count = err_count_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_uart_char_xform.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_char_xform
//  Description : Self-checking bench for uart_char_xform. A fast instance
//                (RX=TX rate) covers transforms, latency, framing errors and
//                mid-frame reset; a slow-TX instance covers FIFO overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_char_xform;
    localparam int CLK_F  = 1_843_200;
    localparam int RX_B   = 115_200;
    localparam int SLOW_B = 9_600;
    localparam int DEPTH  = 4;
    localparam int RXT    = CLK_F / RX_B;
    localparam int TXT_S  = CLK_F / SLOW_B;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    uart_char_xform_if #(.FIFO_DEPTH(DEPTH)) f_if ();
    uart_char_xform_if #(.FIFO_DEPTH(DEPTH)) s_if ();

    uart_char_xform #(.CLOCK_FREQ(CLK_F), .RX_BAUD_RATE(RX_B), .TX_BAUD_RATE(RX_B),
                      .FIFO_DEPTH(DEPTH)) u_fast (.clock(clock), .reset(reset), .bus(f_if));
    uart_char_xform #(.CLOCK_FREQ(CLK_F), .RX_BAUD_RATE(RX_B), .TX_BAUD_RATE(SLOW_B),
                      .FIFO_DEPTH(DEPTH)) u_slow (.clock(clock), .reset(reset), .bus(s_if));

    int total = 0;
    int bad   = 0;
    int ferr_f = 0, ovf_f = 0, ferr_s = 0, ovf_s = 0, peak_s = 0;
    int stop_bad_f = 0, stop_bad_s = 0;
    logic [7:0] got_f[$];
    logic [7:0] got_s[$];

    always @(negedge clock) begin
        if (f_if.frame_err === 1'b1) ferr_f++;
        if (f_if.rx_ovf === 1'b1)    ovf_f++;
        if (s_if.frame_err === 1'b1) ferr_s++;
        if (s_if.rx_ovf === 1'b1)    ovf_s++;
        if (int'(s_if.fifo_level) > peak_s) peak_s = int'(s_if.fifo_level);
    end

    // Reference: case rules stated on character ranges.
    function automatic logic [7:0] model(input logic [7:0] c, input logic [1:0] m);
        bit lower, upper;
        lower = (c >= "a") && (c <= "z");
        upper = (c >= "A") && (c <= "Z");
        case (m)
            2'd1:    return lower ? c - 8'd32 : c;
            2'd2:    return upper ? c + 8'd32 : c;
            2'd3:    return lower ? c - 8'd32 : (upper ? c + 8'd32 : c);
            default: return c;
        endcase
    endfunction

    function automatic logic tx_of(input bit sel);
        return sel ? s_if.tx : f_if.tx;
    endfunction

    // Frame decoder on the serial output, sampling at bit centres.
    task automatic monitor(input bit sel, input int ticks);
        logic [7:0] b;
        forever begin
            @(negedge clock);
            if (!reset && tx_of(sel) == 1'b0) begin
                repeat (ticks / 2) @(negedge clock);
                for (int i = 0; i < 8; i++) begin
                    repeat (ticks) @(negedge clock);
                    b[i] = tx_of(sel);
                end
                repeat (ticks) @(negedge clock);
                if (tx_of(sel) !== 1'b1) begin
                    if (sel) stop_bad_s++; else stop_bad_f++;
                end
                if (sel) got_s.push_back(b); else got_f.push_back(b);
            end
        end
    endtask

    initial monitor(1'b0, RXT);
    initial monitor(1'b1, TXT_S);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rx(input bit sel, input logic v);
        if (sel) s_if.rx = v; else f_if.rx = v;
    endtask

    task automatic send(input bit sel, input logic [7:0] b, input logic stop);
        set_rx(sel, 1'b0);
        repeat (RXT) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            set_rx(sel, b[i]);
            repeat (RXT) @(negedge clock);
        end
        set_rx(sel, stop);
        repeat (RXT) @(negedge clock);
        set_rx(sel, 1'b1);
    endtask

    task automatic wait_n(input bit sel, input int n, input int limit);
        for (int i = 0; i < limit; i++) begin
            if ((sel ? got_s.size() : got_f.size()) >= n) break;
            @(negedge clock);
        end
    endtask

    task automatic expect_byte(input bit sel, input string tag, input logic [7:0] exp);
        logic [7:0] v;
        wait_n(sel, 1, 40 * RXT + 20 * TXT_S);
        if (sel) v = (got_s.size() > 0) ? got_s.pop_front() : 8'hxx;
        else     v = (got_f.size() > 0) ? got_f.pop_front() : 8'hxx;
        check(tag, {24'd0, v}, {24'd0, exp});
    endtask

    initial begin
        logic [7:0] b;
        logic [1:0] m;
        int base_fe, base_ov, lat, k;
        logic [7:0] ovf_str[8];

        f_if.rx = 1'b1; s_if.rx = 1'b1;
        f_if.mode = 2'd0; s_if.mode = 2'd0;
        repeat (4) @(negedge clock);
        check("rst_tx", {31'd0, f_if.tx}, 32'd1);
        check("rst_busy", {31'd0, f_if.tx_busy}, 32'd0);
        check("rst_ovf", {31'd0, f_if.rx_ovf}, 32'd0);
        check("rst_ferr", {31'd0, f_if.frame_err}, 32'd0);
        check("rst_level", 32'(f_if.fifo_level), 32'd0);
        reset = 1'b0;
        repeat (4 * RXT) @(negedge clock);

        // First byte, with push-to-start-bit latency measured alongside.
        base_fe = ferr_f; base_ov = ovf_f;
        f_if.mode = 2'd1;
        lat = 0; k = 0;
        fork
            send(1'b0, "a", 1'b1);
            begin
                while (f_if.fifo_level != 1 && k < 20 * RXT) begin @(negedge clock); k++; end
                while (f_if.tx !== 1'b0 && lat < 20) begin @(negedge clock); lat++; end
            end
        join
        check("latency", lat, 32'd2);
        expect_byte(1'b0, "upper_a", 8'h41);
        check("a_ferr", ferr_f - base_fe, 32'd0);
        check("a_ovf", ovf_f - base_ov, 32'd0);
        check("a_level", 32'(f_if.fifo_level), 32'd0);

        f_if.mode = 2'd2; send(1'b0, "Q", 1'b1); expect_byte(1'b0, "lower_Q", 8'h71);
        f_if.mode = 2'd3; send(1'b0, "b", 1'b1); expect_byte(1'b0, "swap_b", 8'h42);
        send(1'b0, "C", 1'b1); expect_byte(1'b0, "swap_C", 8'h63);
        f_if.mode = 2'd0; send(1'b0, "z", 1'b1); expect_byte(1'b0, "pass_z", 8'h7A);
        for (int i = 0; i < 4; i++) begin
            f_if.mode = 2'(i);
            send(1'b0, 8'h2C, 1'b1); expect_byte(1'b0, "comma", 8'h2C);
            send(1'b0, 8'h35, 1'b1); expect_byte(1'b0, "five", 8'h35);
        end

        // Random bytes and modes; mode is changed again once the frame is underway.
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom_range(0, 255));
            if (i % 2 == 0) b = 8'($urandom_range(8'h41, 8'h7A));
            m = 2'($urandom_range(0, 3));
            f_if.mode = m;
            send(1'b0, b, 1'b1);
            k = 0;
            while (f_if.tx_busy !== 1'b1 && k < 20 * RXT) begin @(negedge clock); k++; end
            f_if.mode = 2'($urandom_range(0, 3));
            expect_byte(1'b0, "random", model(b, m));
        end

        // Bad stop bit: dropped with one frame_err pulse.
        base_fe = ferr_f;
        send(1'b0, 8'h55, 1'b0);
        repeat (15 * RXT) @(negedge clock);
        check("ferr_pulse", ferr_f - base_fe, 32'd1);
        check("ferr_nothing_tx", got_f.size(), 32'd0);
        check("ferr_level", 32'(f_if.fifo_level), 32'd0);
        f_if.mode = 2'd1; send(1'b0, "s", 1'b1); expect_byte(1'b0, "after_ferr", 8'h53);

        // Overflow on the slow-TX instance: 8 back-to-back bytes into depth 4.
        s_if.mode = 2'd1;
        base_ov = ovf_s; base_fe = ferr_s;
        ovf_str = '{"a", "b", "c", "d", "e", "f", "g", "h"};
        for (int i = 0; i < 8; i++) send(1'b1, ovf_str[i], 1'b1);
        wait_n(1'b1, 5, 14 * TXT_S * 10);
        repeat (15 * TXT_S) @(negedge clock);
        check("ovf_count_out", got_s.size(), 32'd5);
        for (int i = 0; i < 5; i++) expect_byte(1'b1, "ovf_order", model(ovf_str[i], 2'd1));
        check("ovf_pulses", ovf_s - base_ov, 32'd3);
        check("ovf_peak", peak_s, 32'd4);
        check("ovf_ferr", ferr_s - base_fe, 32'd0);
        check("ovf_level", 32'(s_if.fifo_level), 32'd0);
`ifdef UART_XFORM_STATS_EN
        check("stat_rx", 32'(s_if.rx_count), 32'd5);
        check("stat_tx", 32'(s_if.tx_count), 32'd5);
        check("stat_err", 32'(s_if.err_count), 32'd3);
`endif

        // Reset during data bit 3 with rx held low across release.
        f_if.mode = 2'd0;
        send(1'b0, 8'h5A, 1'b1);
        k = 0;
        while (f_if.tx_busy !== 1'b1 && k < 20 * RXT) begin @(negedge clock); k++; end
        repeat (4 * RXT + RXT / 2) @(negedge clock);
        f_if.rx = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("mid_rst_tx", {31'd0, f_if.tx}, 32'd1);
        check("mid_rst_busy", {31'd0, f_if.tx_busy}, 32'd0);
        check("mid_rst_level", 32'(f_if.fifo_level), 32'd0);
        reset = 1'b0;
        base_fe = ferr_f;
        repeat (3 * RXT) @(negedge clock);
        f_if.rx = 1'b1;
        repeat (5 * RXT) @(negedge clock);
        got_f.delete();
        repeat (15 * RXT) @(negedge clock);
        check("arm_no_rx", got_f.size(), 32'd0);
        check("arm_level", 32'(f_if.fifo_level), 32'd0);
        check("arm_busy", {31'd0, f_if.tx_busy}, 32'd0);
        check("arm_ferr", ferr_f - base_fe, 32'd0);
        f_if.mode = 2'd1; send(1'b0, "s", 1'b1); expect_byte(1'b0, "after_rst", 8'h53);

        check("stop_bits_fast", stop_bad_f, 32'd0);
        check("stop_bits_slow", stop_bad_s, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
